// File: rtl/point_generator_pkg.sv
// Shared fixed-point constants, FSM state encoding and multiply helper
// for the per-pixel Mandelbrot iteration unit.
package point_generator_pkg;

  localparam int PG_HBP  = 64;
  localparam int PG_HBS  = 64;
  localparam int PG_HBI  = 32;
  localparam int PG_FRAC = PG_HBP - 8;

  localparam logic signed [PG_HBP-1:0] ESCAPE_SQ = 64'sd4 <<< PG_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } pg_state_e;

  // Full-width signed product, arithmetic shift back to FRAC, wrap to HBP bits.
  function automatic logic signed [PG_HBP-1:0] fx_mul(input logic signed [PG_HBP-1:0] a,
                                                      input logic signed [PG_HBP-1:0] b);
    logic signed [2*PG_HBP-1:0] p;
    p = $signed({{PG_HBP{a[PG_HBP-1]}}, a}) * $signed({{PG_HBP{b[PG_HBP-1]}}, b});
    p = p >>> PG_FRAC;
    return p[PG_HBP-1:0];
  endfunction

endpackage

// File: rtl/point_generator_step.sv
// One combinational Mandelbrot step: next z = z^2 + c, plus escape test on the current z.
module mandel_step
  import point_generator_pkg::*;
(
  input  logic signed [PG_HBP-1:0] zr,
  input  logic signed [PG_HBP-1:0] zi,
  input  logic signed [PG_HBP-1:0] c_re,
  input  logic signed [PG_HBP-1:0] c_im,
  output logic signed [PG_HBP-1:0] zr_next,
  output logic signed [PG_HBP-1:0] zi_next,
  output logic                     escape
);

  logic signed [PG_HBP-1:0] zr_sq, zi_sq, zr_zi;
  logic signed [PG_HBP:0]   mag_sq;

  assign zr_sq = fx_mul(zr, zr);
  assign zi_sq = fx_mul(zi, zi);
  assign zr_zi = fx_mul(zr, zi);

  // One extra bit keeps the sum exact while |z| <= 2.
  assign mag_sq = {zr_sq[PG_HBP-1], zr_sq} + {zi_sq[PG_HBP-1], zi_sq};
  assign escape = mag_sq > $signed({1'b0, ESCAPE_SQ});

  assign zr_next = zr_sq - zi_sq + c_re;
  assign zi_next = {zr_zi[PG_HBP-2:0], 1'b0} + c_im;

endmodule

// File: rtl/point_generator.sv
// Per-pixel Mandelbrot iteration unit: map pixel to c, iterate until escape
// or the iteration limit, then hold the count with ready high.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | sample x/y/scales/origins, compute c, clear z and count
// ITER  | one escape test and z update per cycle
// DONE  | result held with ready high until start or RST
module point_generator
  import point_generator_pkg::*;
#(
  parameter int HBP  = PG_HBP,
  parameter int HBS  = PG_HBS,
  parameter int HBI  = PG_HBI,
  parameter int FRAC = PG_FRAC
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [HBS-1:0]        re_scale,
  input  logic [HBS-1:0]        im_scale,
  input  logic [11:0]           x,
  input  logic [11:0]           y,
  input  logic [HBI-1:0]        max_iterations,
  input  logic signed [HBP-1:0] re_start,
  input  logic signed [HBP-1:0] im_start,
  output logic                  ready,
  output logic [HBI-1:0]        iteration
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_ITER = ITER;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]            state;
  logic signed [HBP-1:0] zr, zi, c_re, c_im;
  logic signed [HBP-1:0] zr_next, zi_next;
  logic                  escape;
  logic [HBI-1:0]        count;
  logic [HBS+11:0]       re_off, im_off;

  assign re_off = {{HBS{1'b0}}, x} * {12'd0, re_scale};
  assign im_off = {{HBS{1'b0}}, y} * {12'd0, im_scale};

  mandel_step u_step (
    .zr      (zr),
    .zi      (zi),
    .c_re    (c_re),
    .c_im    (c_im),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escape  (escape)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      ready     <= 1'b0;
      iteration <= '0;
      zr        <= '0;
      zi        <= '0;
      c_re      <= '0;
      c_im      <= '0;
      count     <= '0;
    end else if (start) begin
      // Any start abandons whatever is in flight.
      state <= ST_LOAD;
      ready <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          c_re  <= re_start + $signed(re_off[HBP-1:0]);
          c_im  <= im_start + $signed(im_off[HBP-1:0]);
          zr    <= '0;
          zi    <= '0;
          count <= '0;
          state <= ST_ITER;
        end
        ST_ITER: begin
          if (count == max_iterations || escape) begin
            iteration <= count;
            ready     <= 1'b1;
            state     <= ST_DONE;
          end else begin
            zr    <= zr_next;
            zi    <= zi_next;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_generator.sv
// Directed-vector bench for point_generator with hand-computed iteration counts and latencies.
module tb_point_generator;

  logic               CLK = 1'b0;
  logic               RST;
  logic               start;
  logic [63:0]        re_scale, im_scale;
  logic [11:0]        x, y;
  logic [31:0]        max_iterations;
  logic signed [63:0] re_start, im_start;
  logic               ready;
  logic [31:0]        iteration;

  int checks = 0;
  int errors = 0;

  localparam logic signed [63:0] ONE     = 64'sd1 <<< 56;
  localparam logic signed [63:0] TWO     = 64'sd2 <<< 56;
  localparam logic signed [63:0] NEG_TWO = -(64'sd2 <<< 56);
  localparam logic [63:0]        QUARTER = 64'd1 << 54;

  point_generator dut (
    .CLK            (CLK),
    .RST            (RST),
    .start          (start),
    .re_scale       (re_scale),
    .im_scale       (im_scale),
    .x              (x),
    .y              (y),
    .max_iterations (max_iterations),
    .re_start       (re_start),
    .im_start       (im_start),
    .ready          (ready),
    .iteration      (iteration)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start at edge E0 with x0 sampled, switch x to x1 on the negedge after E0,
  // then measure edges after E0 until ready.
  task automatic run(input string tag, input logic signed [63:0] rs, input logic [63:0] sc,
                     input logic [11:0] x0, input logic [11:0] x1, input logic [31:0] mi,
                     input int exp_it, input int exp_lat);
    int lat;
    @(negedge CLK);
    re_start = rs; re_scale = sc; x = x0; max_iterations = mi; start = 1'b1;
    @(posedge CLK); #1;
    chk({tag, "_rdy_low"}, 64'(ready), 64'd0);
    @(negedge CLK);
    start = 1'b0; x = x1;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!ready && lat < 600);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_iter"}, 64'(iteration), 64'(exp_it));
    repeat (3) @(posedge CLK);
    #1;
    chk({tag, "_hold_rdy"}, 64'(ready), 64'd1);
    chk({tag, "_hold_iter"}, 64'(iteration), 64'(exp_it));
  endtask

  initial begin
    RST = 1'b1; start = 1'b0;
    re_scale = '0; im_scale = '0; x = '0; y = '0;
    max_iterations = 32'd255; re_start = '0; im_start = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_iter", 64'(iteration), 64'd0);
    @(negedge CLK); RST = 1'b0;

    // c = -2 + 12*0.25 = 1: z = 0,1,2,5 -> escapes at count 3
    run("c_one", NEG_TWO, QUARTER, 12'd12, 12'd12, 32'd255, 3, 5);
    // c = 2: |z|^2 = 4 at count 1 does not escape, z = 6 does
    run("c_two", TWO, 64'd0, 12'd0, 12'd0, 32'd255, 2, 4);
    run("c_zero", 64'sd0, 64'd0, 12'd0, 12'd0, 32'd255, 255, 257);
    run("c_neg2", NEG_TWO, 64'd0, 12'd0, 12'd0, 32'd255, 255, 257);
    run("max0", TWO, 64'd0, 12'd0, 12'd0, 32'd0, 0, 2);
    // x is 0 (c = -2, never escapes) in the start cycle, 12 (c = 1) in LOAD
    run("x_late", NEG_TWO, QUARTER, 12'd0, 12'd12, 32'd255, 3, 5);

    // Restart mid-ITER on a non-escaping point, then run c = 1.
    @(negedge CLK);
    re_start = 64'sd0; re_scale = '0; x = '0; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("restart_busy", 64'(ready), 64'd0);
    run("restart", NEG_TWO, QUARTER, 12'd12, 12'd12, 32'd255, 3, 5);

    // Reset in ITER clears outputs; nothing appears until the next start.
    @(negedge CLK);
    re_start = 64'sd0; re_scale = '0; x = '0; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_iter", 64'(iteration), 64'd0);
    repeat (20) @(negedge CLK);
    chk("rst_quiet_ready", 64'(ready), 64'd0);
    chk("rst_quiet_iter", 64'(iteration), 64'd0);
    run("after_rst", TWO, 64'd0, 12'd0, 12'd0, 32'd255, 2, 4);

    // Points at c = 1 via im path would need im_scale; keep c = ONE direct origin too.
    run("origin_one", ONE, 64'd0, 12'd0, 12'd0, 32'd255, 3, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
